// File: rtl/snake_pixel_gen.sv
// Snake board pixel source: cell-map RAM with wall border, food blink and
// a self-clearing sweep, plus a once-per-frame tick for game stepping.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | map stable, game-logic writes accepted, clr starts a sweep
// S_CLEAR | sweeping caddr 0..2047 writing empty cells, busy=1
module snake_pixel_gen #(
    parameter int          CELL_SHIFT   = 4,
    parameter int          COLS         = 40,
    parameter int          ROWS         = 30,
    parameter int          BLINK_FRAMES = 16,
    parameter logic [11:0] C_WALL       = 12'h888,
    parameter logic [11:0] C_BODY       = 12'h0F0,
    parameter logic [11:0] C_HEAD       = 12'h0FF,
    parameter logic [11:0] C_FOOD       = 12'h00F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  row,
    input  logic [9:0]  col,
    input  logic        rdn,
    input  logic        we,
    input  logic [10:0] waddr,
    input  logic [1:0]  wdata,
    input  logic        clr,
    output logic [11:0] pixel,
    output logic        busy,
    output logic        frame_tick
);

    localparam logic [9:0]  H_ACT   = 10'(COLS << CELL_SHIFT);
    localparam logic [9:0]  V_ACT   = 10'(ROWS << CELL_SHIFT);
    localparam logic [5:0]  CX_LAST = 6'(COLS - 1);
    localparam logic [4:0]  CY_LAST = 5'(ROWS - 1);
    localparam int          BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t        state;
    logic [10:0]   caddr;
    logic [1:0]    mem [2048];
    logic          last_px;
    logic [BW-1:0] blink_cnt;
    logic          food_on;

    logic [5:0]    cx;
    logic [4:0]    cy;
    logic [1:0]    code;
    logic          active;
    logic          wall;
    logic          at_last;

    assign cx      = col[CELL_SHIFT +: 6];
    assign cy      = row[CELL_SHIFT +: 5];
    assign code    = mem[{cy, cx}];
    assign active  = !rdn && (row < V_ACT) && (col < H_ACT);
    assign wall    = (cx == 6'd0) || (cx == CX_LAST) || (cy == 5'd0) || (cy == CY_LAST);
    assign at_last = !rdn && (row == V_ACT - 10'd1) && (col == H_ACT - 10'd1);

    // Sweep owns the write port while clearing, so game writes are dropped.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[caddr] <= 2'b00;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            caddr <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    caddr <= caddr + 11'd1;
                    if (caddr == 11'h7FF) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (clr) begin
                        state <= S_CLEAR;
                        caddr <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    caddr <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_px   <= 1'b0;
            blink_cnt <= '0;
            food_on   <= 1'b1;
        end else begin
            last_px <= at_last;
            if (last_px) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    food_on   <= ~food_on;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    assign frame_tick = last_px;

    always_comb begin
        pixel = 12'h000;
        if (active) begin
            if (wall) begin
                pixel = C_WALL;
            end else begin
                case (code)
                    2'b01:   pixel = C_BODY;
                    2'b10:   pixel = C_HEAD;
                    2'b11:   pixel = food_on ? C_FOOD : 12'h000;
                    default: pixel = 12'h000;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snake_pixel_gen.sv
// Self-checking bench for snake_pixel_gen: directed board scenarios plus
// randomized writes/reads against a cell-array reference model.
module tb_snake_pixel_gen;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [9:0]  row   = '0;
    logic [9:0]  col   = '0;
    logic        rdn   = 1'b1;
    logic        we    = 1'b0;
    logic [10:0] waddr = '0;
    logic [1:0]  wdata = '0;
    logic        clr   = 1'b0;
    logic [11:0] pixel;
    logic        busy;
    logic        frame_tick;

    snake_pixel_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row        (row),
        .col        (col),
        .rdn        (rdn),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .clr        (clr),
        .pixel      (pixel),
        .busy       (busy),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain cell array, cycles left in the sweep, frames seen.
    int mem_m [2048];
    int sweep_left;
    int frame_count;
    bit tick_exp;
    int ft_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        foreach (mem_m[i]) mem_m[i] = 0;
    endtask

    task automatic model_reset();
        sweep_left  = 2048;
        frame_count = 0;
        tick_exp    = 1'b0;
        clear_model();
    endtask

    function automatic logic [11:0] exp_px(input int r, input int c, input bit rd);
        int cx, cy, code;
        bit fon;
        if (rd || r >= 480 || c >= 640) return 12'h000;
        cx = c / 16;
        cy = r / 16;
        if (cx == 0 || cx == 39 || cy == 0 || cy == 29) return 12'h888;
        code = mem_m[cy * 64 + cx];
        fon  = ((frame_count / 16) % 2) == 0;
        case (code)
            1:       return 12'h0F0;
            2:       return 12'h0FF;
            3:       return fon ? 12'h00F : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    // One clock: model transitions from pre-edge inputs, then check busy/tick.
    task automatic step();
        bit lp, do_w, do_c;
        lp   = (rdn == 1'b0) && (row == 10'd479) && (col == 10'd639);
        do_w = we && (sweep_left == 0);
        do_c = clr && (sweep_left == 0);
        @(posedge clk);
        if (sweep_left > 0) sweep_left--;
        if (do_w) mem_m[waddr] = wdata;
        if (do_c) begin
            sweep_left = 2048;
            clear_model();
        end
        if (tick_exp) frame_count++;
        tick_exp = lp;
        #1;
        if (frame_tick === 1'b1) ft_count++;
        chk("busy", busy, sweep_left > 0);
        chk("frame_tick", frame_tick, tick_exp);
    endtask

    task automatic probe(input string tag, input int r, input int c, input bit rd);
        row = 10'(r);
        col = 10'(c);
        rdn = rd;
        #1;
        chk(tag, pixel, exp_px(r, c, rd));
        step();
    endtask

    task automatic wr(input int y, input int x, input int d);
        we    = 1'b1;
        waddr = {5'(y), 6'(x)};
        wdata = 2'(d);
        step();
        we    = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        we    = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", busy, 1'b1);
        chk("rst_frame_tick", frame_tick, 1'b0);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic sweep_len(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            step();
            n++;
        end
        chk(tag, n, 2048);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ft_count = 0;
        model_reset();
        #2;
        do_reset(3);
        sweep_len("reset_sweep_len");
        probe("interior_cleared", 100, 200, 1'b0);

        // body cell and its boundaries
        wr(3, 5, 1);
        probe("body_tl", 48, 80, 1'b0);
        probe("body_br", 63, 95, 1'b0);
        row = 10'd50; col = 10'd90; rdn = 1'b0; #1;
        chk("body_const", pixel, 12'h0F0);
        step();
        probe("body_right_nb", 48, 96, 1'b0);
        probe("body_rdn1", 48, 80, 1'b1);

        // walls
        probe("wall_00", 0, 0, 1'b0);
        probe("wall_last", 479, 639, 1'b0);
        wr(0, 0, 2);
        row = 10'd0; col = 10'd0; rdn = 1'b0; #1;
        chk("wall_over_head", pixel, 12'h888);
        step();
        probe("row480", 480, 100, 1'b0);
        probe("col640", 100, 640, 1'b0);

        // write/read collision
        row = 10'd32; col = 10'd32; rdn = 1'b0;
        we = 1'b1; waddr = {5'd2, 6'd2}; wdata = 2'b01;
        #1;
        chk("collide_old", pixel, 12'h000);
        step();
        we = 1'b0;
        #1;
        chk("collide_new", pixel, 12'h0F0);
        step();

        // randomized writes and reads
        for (int i = 0; i < 400; i++) begin
            int k;
            k = $urandom_range(0, 3);
            if (k == 0) begin
                wr($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 3));
            end else if (k == 1) begin
                probe("rand_any", $urandom_range(0, 524), $urandom_range(0, 799),
                      $urandom_range(0, 3) == 0);
            end else begin
                probe("rand_cell", $urandom_range(0, 29) * 16 + $urandom_range(0, 15),
                      $urandom_range(0, 39) * 16 + $urandom_range(0, 15), 1'b0);
            end
        end

        // clear interactions: dropped write, ignored second clr
        clr = 1'b1;
        step();
        clr = 1'b0;
        n = 1;
        repeat (99) begin step(); n++; end
        wr(1, 5, 1); n++;
        wr(0, 5, 1); n++;
        while (n < 500) begin step(); n++; end
        clr = 1'b1;
        step(); n++;
        clr = 1'b0;
        while (busy && n < 3000) begin step(); n++; end
        chk("clr_sweep_len", n, 2049);
        row = 10'd19; col = 10'd83; rdn = 1'b0; #1;
        chk("dropped_write", pixel, 12'h000);
        step();
        probe("dropped_model", 19, 83, 1'b0);

        // write and clr in the same idle cycle
        we = 1'b1; waddr = {5'd5, 6'd5}; wdata = 2'b01; clr = 1'b1;
        step();
        we = 1'b0; clr = 1'b0;
        sweep_len("we_clr_sweep_len");
        row = 10'd85; col = 10'd85; rdn = 1'b0; #1;
        chk("we_clr_cleared", pixel, 12'h000);
        step();

        // mid-sweep reset with frame_tick high
        rdn = 1'b1;
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (1000) step();
        row = 10'd479; col = 10'd639; rdn = 1'b0;
        step();
        rdn = 1'b1;
        chk("tick_before_rst", frame_tick, 1'b1);
        do_reset(2);
        sweep_len("midrst_sweep_len");

        // food blink over 33 frames
        wr(10, 10, 3);
        for (int f = 0; f <= 32; f++) begin
            int t0;
            row = 10'd160; col = 10'd160; rdn = 1'b0; #1;
            chk("food_blink", pixel, ((f / 16) % 2 == 0) ? 12'h00F : 12'h000);
            chk("food_model", pixel, exp_px(160, 160, 1'b0));
            step();
            t0 = ft_count;
            probe("near_last", 479, 638, 1'b0);
            probe("last_rdn1", 479, 639, 1'b1);
            probe("last_px", 479, 639, 1'b0);
            probe("after_last", $urandom_range(0, 479), $urandom_range(0, 639), 1'b1);
            probe("frame_rand", $urandom_range(0, 478), $urandom_range(0, 639), 1'b0);
            chk("ticks_per_frame", ft_count - t0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_pixel_gen.md
Name: snake_pixel_gen

Overview:
- Pixel source directly upstream of the VGA timing stage.
- Takes the stage's registered row/col/rdn and returns the 12-bit pixel (bbbb_gggg_rrrr) in the same cycle.
- Holds the game-board cell map (40x30 cells of 16x16 px) in a RAM written by game logic, draws the wall border and blinks food.
- Self-clears the map after reset or on request, and produces a once-per-frame tick for game stepping.

Parameters:
- CELL_SHIFT, 4, log2 of cell size in pixels (16x16).
- COLS, 40, board width in cells (640 >> CELL_SHIFT).
- ROWS, 30, board height in cells (480 >> CELL_SHIFT).
- BLINK_FRAMES, 16, frames per food blink phase.
- C_WALL, 12'h888, wall colour.
- C_BODY, 12'h0F0, body colour.
- C_HEAD, 12'h0FF, head colour.
- C_FOOD, 12'h00F, food colour.

Ports:
- clk  in  1  pixel clock, shared with the VGA stage.
- rst_n  in  1  asynchronous, active-low reset.
- row  in  10  pixel row from the VGA stage (0-479 when active).
- col  in  10  pixel column from the VGA stage (0-639 when active).
- rdn  in  1  pixel read strobe, active-low.
- we  in  1  cell write enable from game logic.
- waddr  in  11  cell address {y[4:0], x[5:0]}.
- wdata  in  2  cell code: 00 empty, 01 body, 10 head, 11 food.
- clr  in  1  one-cycle request to clear the whole map.
- pixel  out  12  bbbb_gggg_rrrr pixel data, combinational; feeds the VGA stage's Din.
- busy  out  1  clear sweep in progress; writes are ignored while high.
- frame_tick  out  1  one-cycle pulse at end of the active frame.

Behaviour:
- Cell RAM: 2048 x 2 bits, asynchronous read, synchronous write. Contents are not reset.
- Read address = {row[8:4], col[9:4]}. Zero added latency: pixel is a combinational function of the current row/col/rdn and RAM contents.
- Pixel priority:
  - rdn=1, or row>=480, or col>=640: 12'h000.
  - Else wall (cx==0 | cx==COLS-1 | cy==0 | cy==ROWS-1): C_WALL, regardless of RAM content.
  - Else by cell code: 00 -> 12'h000; 01 -> C_BODY; 10 -> C_HEAD; 11 -> C_FOOD if food_on, else 12'h000.
- Write: on a clk edge with we=1 and busy=0, RAM[waddr] <= wdata.
  - If waddr addresses the pixel being read that cycle, pixel shows the old content; the new content is visible from the next cycle.
  - waddr beyond the used cells (x>=40 or y>=30) is written but never displayed.
- Clear FSM, states IDLE and CLEAR:
  - Reset enters CLEAR with caddr=0 and busy=1.
  - In CLEAR: each cycle RAM[caddr] <= 00 and caddr += 1. After writing caddr=2047 -> IDLE, busy=0 on the next cycle. A full sweep takes 2048 cycles.
  - In IDLE: clr=1 -> CLEAR with caddr=0, busy=1 from the next cycle.
  - clr during CLEAR is ignored; the sweep is not restarted.
  - we during CLEAR is dropped.
  - we and clr in the same IDLE cycle: the write is performed, then the sweep clears it.
  - rst_n low mid-sweep: restart in CLEAR with caddr=0.
- Frame tick:
  - Register last_px = (rdn==0 && row==479 && col==639).
  - frame_tick = last_px: a pulse exactly one cycle after that pixel is presented, once per frame.
- Blink:
  - blink_cnt counts frame_ticks from 0 to BLINK_FRAMES-1, then wraps to 0.
  - food_on toggles on each wrap; the period is 2*BLINK_FRAMES frames.
- Reset values: busy=1, frame_tick=0, last_px=0, blink_cnt=0, food_on=1, state=CLEAR, caddr=0. pixel follows its combinational definition.
- Width rules:
  - Cell x/y are truncations of col/row; no division.
  - caddr is 11 bits; reaching 2047 ends the sweep with no wrap into a second pass.

Test Plan:
- Reset, then hold rst_n=1 -> busy=1 for exactly 2048 cycles then 0. A read of any interior cell (row=100, col=200) gives pixel=12'h000.
- After the clear, write we=1 waddr={5'd3,6'd5} wdata=01 -> row=48..63, col=80..95 with rdn=0 gives 12'h0F0. col=96 gives 12'h000. rdn=1 gives 12'h000.
- Wall: row=0 col=0 -> 12'h888. row=479 col=639 -> 12'h888. Write head (10) to cell {0,0}: still 12'h888. row=480 -> 12'h000.
- Food {5'd10,6'd10}=11 with full frame timing driven:
  - frame_tick pulses once per frame, one cycle after row=479/col=639.
  - Pixel at row=160 col=160 is 12'h00F for frames 0-15, 12'h000 for frames 16-31, 12'h00F again at frame 32.
- Clear interactions:
  - clr pulse, then we to cell 5 at sweep cycle 100 -> the write is dropped.
  - Second clr at cycle 500 -> busy still falls at cycle 2048 after the first clr.
- Collision and mid-sweep reset:
  - Write cell {2,2}=01 while row=32 col=32 is presented -> pixel 12'h000 that cycle, 12'h0F0 the next.
  - Assert rst_n=0 mid-sweep -> busy=1 and frame_tick=0 immediately; a full 2048-cycle sweep follows release.
